rob_commit_queue: RTL and testbench
===================================

Name: rob_commit_queue

Overview:
- Reorder buffer for the out-of-order RISC-V core. It allocates ROB tags at issue and captures results broadcast on the CDB.
- It retires entries in program order. Each retirement drives the commit interface (rob_en/rob_dest/rob_tag/rob_data) into the producer table and the register file.
- It also provides operand bypass for values that have completed but not yet committed.

Parameters:
- TAG_W, 4, tag width. DEPTH = 2**TAG_W entries (16).
- DATA_W, 32, result data width.
- REG_ADDR_W, 5, architectural register address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- issue_en  in  1  allocate one entry this cycle
- issue_rd  in  REG_ADDR_W  destination register of the issuing instruction
- issue_ready  out  1  entry available (not full)
- issue_tag  out  TAG_W  tag granted to the issuing instruction (current tail)
- cdb_en  in  1  result broadcast valid
- cdb_tag  in  TAG_W  tag of the broadcast result
- cdb_data  in  DATA_W  broadcast result value
- r1_tag  in  TAG_W  producer tag of source operand 1
- r2_tag  in  TAG_W  producer tag of source operand 2
- r1_done  out  1  operand 1 value available from the ROB
- r1_data  out  DATA_W  operand 1 value
- r2_done  out  1  operand 2 value available from the ROB
- r2_data  out  DATA_W  operand 2 value
- rob_en  out  1  commit strobe, one entry per cycle
- rob_dest  out  REG_ADDR_W  destination register of the committing entry
- rob_tag  out  TAG_W  tag of the committing entry
- rob_data  out  DATA_W  result of the committing entry
- flush  in  1  discard all entries (mispredict or exception)
- count  out  TAG_W+1  number of occupied entries

Behaviour:
- Per-entry state: valid, done, dest, data.
- Pointers: head, tail (TAG_W bits, wrap naturally at DEPTH), cnt (TAG_W+1 bits). Full when cnt==DEPTH; empty when cnt==0.
- Reset: all valid/done cleared, head=tail=cnt=0. Outputs after reset: issue_ready=1, issue_tag=0, rob_en=0, count=0, r*_done=0.
- Issue:
  - issue_tag = tail, combinational.
  - When issue_en && issue_ready, the next edge sets entry[tail] to valid=1, done=0, dest=issue_rd; tail increments.
  - issue_en while full is ignored: no state change.
- Completion:
  - When cdb_en and entry[cdb_tag].valid, the next edge sets done=1 and data=cdb_data.
  - cdb_en to an invalid entry is ignored.
  - A repeated CDB to an already-done entry overwrites data.
- Commit:
  - rob_en = entry[head].valid && entry[head].done, combinational from registered state.
  - rob_dest, rob_tag=head, and rob_data are taken from the head entry. When rob_en=0, rob_dest=0, rob_tag=0, rob_data=0.
  - When rob_en, the next edge clears entry[head].valid/done and head increments.
  - Latency: a CDB write at edge N produces rob_en in cycle N+1, provided the entry is at head.
  - No commit is possible in the same cycle as that entry's CDB write.
- x0 destinations are allocated and committed normally with rob_dest=0. Consumers ignore them.
- Simultaneous issue and commit: cnt is unchanged; both pointers advance.
- issue_ready = !full. It does not count a same-cycle commit, so a full ROB refuses issue even while committing.
- Bypass:
  - r1_done = entry[r1_tag].valid && (entry[r1_tag].done || (cdb_en && cdb_tag==r1_tag)).
  - r1_data = cdb_data when the CDB matches this cycle, else entry data. Operand 2 is identical.
  - Bypass on an invalid entry gives r_done=0, r_data=0.
- Flush:
  - Synchronous. The next edge clears all valid/done and sets head=tail=cnt=0.
  - Flush has priority over issue, CDB and commit in the same cycle.
  - rob_en is forced to 0 in the flush cycle.
- rst has priority over everything. Asserting it mid-operation discards all in-flight entries.

Test Plan:
- Reset, then issue rd=5 and rd=7 (tags 0,1); CDB tag1=0xBB, then tag0=0xAA → no commit after the tag1 write. Then rob_en with rob_dest=5/rob_data=0xAA, next cycle rob_dest=7/0xBB, in order; count returns to 0.
- Issue 16 entries with no completion → issue_ready=0, count=16; a 17th issue_en is ignored. Complete tag0 → after commit, issue_ready=1 and the next issue_tag=0 (wrap).
- Tag 3 valid and not done; drive cdb_en tag3=0x1234 with r1_tag=3 in the same cycle → r1_done=1, r1_data=0x1234. Next cycle, from stored state → still 1/0x1234.
- Fill 6 entries and complete 2, then assert flush together with issue_en and cdb_en → next cycle count=0, issue_tag=0, rob_en=0; the same-cycle issue was not allocated.
- Steady state with count=4: issue_en and a commit in the same cycle → count stays 4, head and tail both advance. Issue with rd=0 → committed with rob_dest=0.
- rst asserted mid-stream with 3 done entries pending → next cycle rob_en=0, count=0, issue_tag=0.

Source files
------------

// File: rtl/rob_commit_queue.sv
// Reorder buffer: allocates tags at issue, captures CDB results, retires in program order
// and bypasses completed-but-uncommitted values to operand readers.
module rob_commit_queue #(
  parameter int TAG_W      = 4,
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_en,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  output logic                  issue_ready,
  output logic [TAG_W-1:0]      issue_tag,
  input  logic                  cdb_en,
  input  logic [TAG_W-1:0]      cdb_tag,
  input  logic [DATA_W-1:0]     cdb_data,
  input  logic [TAG_W-1:0]      r1_tag,
  input  logic [TAG_W-1:0]      r2_tag,
  output logic                  r1_done,
  output logic [DATA_W-1:0]     r1_data,
  output logic                  r2_done,
  output logic [DATA_W-1:0]     r2_data,
  output logic                  rob_en,
  output logic [REG_ADDR_W-1:0] rob_dest,
  output logic [TAG_W-1:0]      rob_tag,
  output logic [DATA_W-1:0]     rob_data,
  input  logic                  flush,
  output logic [TAG_W:0]        count
);

  localparam int DEPTH = 2 ** TAG_W;
  localparam logic [TAG_W:0] FULL_CNT = (TAG_W + 1)'(DEPTH);

  logic [DEPTH-1:0]      valid_q;
  logic [DEPTH-1:0]      done_q;
  logic [REG_ADDR_W-1:0] dest_q [DEPTH];
  logic [DATA_W-1:0]     data_q [DEPTH];
  logic [TAG_W-1:0]      head_q;
  logic [TAG_W-1:0]      tail_q;
  logic [TAG_W:0]        cnt_q;

  logic issue_fire;
  logic commit_fire;
  logic cdb_fire;
  logic r1_hit;
  logic r2_hit;

  assign issue_ready = (cnt_q != FULL_CNT);
  assign issue_tag   = tail_q;
  assign count       = cnt_q;

  // Readiness ignores a same-cycle commit, so a full buffer refuses issue while retiring.
  assign issue_fire  = issue_en && issue_ready;
  assign commit_fire = valid_q[head_q] && done_q[head_q] && !flush;
  assign cdb_fire    = cdb_en && valid_q[cdb_tag];

  assign rob_en   = commit_fire;
  assign rob_dest = commit_fire ? dest_q[head_q] : '0;
  assign rob_tag  = commit_fire ? head_q : '0;
  assign rob_data = commit_fire ? data_q[head_q] : '0;

  assign r1_hit  = cdb_en && (cdb_tag == r1_tag);
  assign r2_hit  = cdb_en && (cdb_tag == r2_tag);
  assign r1_done = valid_q[r1_tag] && (done_q[r1_tag] || r1_hit);
  assign r2_done = valid_q[r2_tag] && (done_q[r2_tag] || r2_hit);
  assign r1_data = !valid_q[r1_tag] ? '0 : (r1_hit ? cdb_data : data_q[r1_tag]);
  assign r2_data = !valid_q[r2_tag] ? '0 : (r2_hit ? cdb_data : data_q[r2_tag]);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_q <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
    end else begin
      if (cdb_fire) begin
        done_q[cdb_tag] <= 1'b1;
        data_q[cdb_tag] <= cdb_data;
      end
      // Commit clear follows the CDB write so a late rewrite of the head cannot resurrect it.
      if (commit_fire) begin
        valid_q[head_q] <= 1'b0;
        done_q[head_q]  <= 1'b0;
        head_q          <= head_q + TAG_W'(1);
      end
      if (issue_fire) begin
        valid_q[tail_q] <= 1'b1;
        done_q[tail_q]  <= 1'b0;
        dest_q[tail_q]  <= issue_rd;
        tail_q          <= tail_q + TAG_W'(1);
      end
      case ({issue_fire, commit_fire})
        2'b10:   cnt_q <= cnt_q + (TAG_W + 1)'(1);
        2'b01:   cnt_q <= cnt_q - (TAG_W + 1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_rob_commit_queue.sv
// Bench for rob_commit_queue: directed scenarios plus randomized traffic checked against
// a program-order queue model of the reorder buffer.
module tb_rob_commit_queue;

  logic        clk = 1'b0;
  logic        rst, issue_en, cdb_en, flush;
  logic [4:0]  issue_rd;
  logic [3:0]  cdb_tag, r1_tag, r2_tag;
  logic [31:0] cdb_data;
  logic        issue_ready, r1_done, r2_done, rob_en;
  logic [3:0]  issue_tag, rob_tag;
  logic [31:0] r1_data, r2_data, rob_data;
  logic [4:0]  rob_dest;
  logic [4:0]  count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rob_commit_queue dut (
    .clk(clk), .rst(rst), .issue_en(issue_en), .issue_rd(issue_rd),
    .issue_ready(issue_ready), .issue_tag(issue_tag), .cdb_en(cdb_en),
    .cdb_tag(cdb_tag), .cdb_data(cdb_data), .r1_tag(r1_tag), .r2_tag(r2_tag),
    .r1_done(r1_done), .r1_data(r1_data), .r2_done(r2_done), .r2_data(r2_data),
    .rob_en(rob_en), .rob_dest(rob_dest), .rob_tag(rob_tag), .rob_data(rob_data),
    .flush(flush), .count(count)
  );

  // Model: in-flight instructions in program order; next_tag is the next tag to hand out.
  typedef struct {
    logic [3:0]  tag;
    logic [4:0]  dest;
    bit          done;
    logic [31:0] data;
  } ent_t;

  ent_t mq[$];
  int   next_tag = 0;

  logic        exp_ready, exp_en, exp_r1_done, exp_r2_done;
  logic [3:0]  exp_itag, exp_rtag;
  logic [4:0]  exp_dest, exp_count;
  logic [31:0] exp_data, exp_r1_data, exp_r2_data;
  bit          exp_r1_known, exp_r2_known;

  function automatic void bypass(input logic [3:0] t, output logic d, output logic [31:0] v,
                                 output bit known);
    d = 1'b0; v = '0; known = 1'b1;
    foreach (mq[i]) begin
      if (mq[i].tag == t) begin
        if (cdb_en && cdb_tag == t) begin d = 1'b1; v = cdb_data; end
        else if (mq[i].done) begin d = 1'b1; v = mq[i].data; end
        else known = 1'b0;
      end
    end
  endfunction

  function automatic void model_exp();
    exp_ready = (mq.size() < 16);
    exp_itag  = 4'(next_tag);
    exp_count = 5'(mq.size());
    exp_en = 1'b0; exp_dest = '0; exp_rtag = '0; exp_data = '0;
    if (!flush && mq.size() > 0) begin
      if (mq[0].done) begin
        exp_en = 1'b1; exp_dest = mq[0].dest; exp_rtag = mq[0].tag; exp_data = mq[0].data;
      end
    end
    bypass(r1_tag, exp_r1_done, exp_r1_data, exp_r1_known);
    bypass(r2_tag, exp_r2_done, exp_r2_data, exp_r2_known);
  endfunction

  function automatic void model_edge();
    ent_t e;
    if (rst || flush) begin
      mq.delete();
      next_tag = 0;
    end else begin
      if (cdb_en)
        foreach (mq[i]) if (mq[i].tag == cdb_tag) begin mq[i].done = 1'b1; mq[i].data = cdb_data; end
      if (exp_en) void'(mq.pop_front());
      if (issue_en && exp_ready) begin
        e.tag = 4'(next_tag); e.dest = issue_rd; e.done = 1'b0; e.data = '0;
        mq.push_back(e);
        next_tag = (next_tag + 1) % 16;
      end
    end
  endfunction

  task automatic settle();
    @(negedge clk);
    model_exp();
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    rst = 0; issue_en = 0; issue_rd = 0; cdb_en = 0; cdb_tag = 0; cdb_data = 0;
    flush = 0; r1_tag = 0; r2_tag = 0;
  endtask

  task automatic do_reset();
    idle(); rst = 1; settle(); tick(); rst = 0; settle(); tick();
  endtask

  task automatic issue_n(input int n);
    for (int i = 0; i < n; i++) begin
      idle(); issue_en = 1; issue_rd = 5'($urandom_range(1, 31)); settle(); tick();
    end
    idle();
  endtask

  task automatic cdb(input logic [3:0] t, input logic [31:0] d);
    idle(); cdb_en = 1; cdb_tag = t; cdb_data = d; settle(); tick(); idle();
  endtask

  task automatic test_reset();
    idle(); rst = 1; settle(); tick(); settle(); tick(); rst = 0; settle();
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_issue_ready: got %b exp 1", issue_ready); end
    checks++; if (issue_tag !== 4'd0) begin errors++; $display("FAIL reset_issue_tag: got %0d exp 0", issue_tag); end
    checks++; if (rob_en !== 1'b0) begin errors++; $display("FAIL reset_rob_en: got %b exp 0", rob_en); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", count); end
    checks++; if (r1_done !== 1'b0 || r2_done !== 1'b0) begin errors++; $display("FAIL reset_r_done: got %b/%b exp 0/0", r1_done, r2_done); end
    tick();
  endtask

  task automatic test_in_order();
    do_reset();
    issue_en = 1; issue_rd = 5; settle();
    checks++; if (issue_tag !== 4'd0) begin errors++; $display("FAIL order_tag0: got %0d exp 0", issue_tag); end
    tick(); issue_rd = 7; settle();
    checks++; if (issue_tag !== 4'd1) begin errors++; $display("FAIL order_tag1: got %0d exp 1", issue_tag); end
    tick();
    cdb(4'd1, 32'hBB);
    cdb_en = 1; cdb_tag = 0; cdb_data = 32'hAA; settle();
    checks++; if (rob_en !== 1'b0) begin errors++; $display("FAIL order_no_early_commit: got %b exp 0", rob_en); end
    tick(); idle(); settle();
    checks++; if ({rob_en, rob_dest, rob_tag, rob_data} !== {1'b1, 5'd5, 4'd0, 32'hAA})
      begin errors++; $display("FAIL order_commit0: got en=%b dest=%0d tag=%0d data=%h exp 1/5/0/aa", rob_en, rob_dest, rob_tag, rob_data); end
    tick(); settle();
    checks++; if ({rob_en, rob_dest, rob_tag, rob_data} !== {1'b1, 5'd7, 4'd1, 32'hBB})
      begin errors++; $display("FAIL order_commit1: got en=%b dest=%0d tag=%0d data=%h exp 1/7/1/bb", rob_en, rob_dest, rob_tag, rob_data); end
    tick(); settle();
    checks++; if (count !== 5'd0 || rob_en !== 1'b0) begin errors++; $display("FAIL order_drained: got count=%0d en=%b exp 0/0", count, rob_en); end
    tick();
  endtask

  task automatic test_full_wrap();
    do_reset();
    issue_n(16);
    issue_en = 1; issue_rd = 9; settle();
    checks++; if (issue_ready !== 1'b0 || count !== 5'd16) begin errors++; $display("FAIL full_state: got ready=%b count=%0d exp 0/16", issue_ready, count); end
    tick(); idle(); settle();
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL full_17th_ignored: got count=%0d exp 16", count); end
    tick();
    cdb(4'd0, 32'h55);
    settle();
    checks++; if (rob_en !== 1'b1 || issue_ready !== 1'b0) begin errors++; $display("FAIL full_commit_refuses_issue: got en=%b ready=%b exp 1/0", rob_en, issue_ready); end
    tick(); settle();
    checks++; if (issue_ready !== 1'b1 || issue_tag !== 4'd0 || count !== 5'd15)
      begin errors++; $display("FAIL full_wrap: got ready=%b tag=%0d count=%0d exp 1/0/15", issue_ready, issue_tag, count); end
    tick();
  endtask

  task automatic test_bypass();
    do_reset();
    issue_n(4);
    cdb_en = 1; cdb_tag = 3; cdb_data = 32'h1234; r1_tag = 3; r2_tag = 9; settle();
    checks++; if (r1_done !== 1'b1 || r1_data !== 32'h1234) begin errors++; $display("FAIL bypass_cdb: got %b/%h exp 1/1234", r1_done, r1_data); end
    checks++; if (r2_done !== 1'b0 || r2_data !== 32'h0) begin errors++; $display("FAIL bypass_invalid: got %b/%h exp 0/0", r2_done, r2_data); end
    tick(); idle(); r1_tag = 3; r2_tag = 2; settle();
    checks++; if (r1_done !== 1'b1 || r1_data !== 32'h1234) begin errors++; $display("FAIL bypass_stored: got %b/%h exp 1/1234", r1_done, r1_data); end
    checks++; if (r2_done !== 1'b0) begin errors++; $display("FAIL bypass_not_done: got %b exp 0", r2_done); end
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    issue_n(6);
    cdb(4'd1, 32'h11);
    cdb(4'd0, 32'h10);
    flush = 1; issue_en = 1; issue_rd = 3; cdb_en = 1; cdb_tag = 2; cdb_data = 32'h22; settle();
    checks++; if (rob_en !== 1'b0 || count !== 5'd6) begin errors++; $display("FAIL flush_cycle: got en=%b count=%0d exp 0/6", rob_en, count); end
    tick(); idle(); r1_tag = 0; settle();
    checks++; if (count !== 5'd0 || issue_tag !== 4'd0 || rob_en !== 1'b0 || r1_done !== 1'b0)
      begin errors++; $display("FAIL flush_after: got count=%0d tag=%0d en=%b r1=%b exp 0/0/0/0", count, issue_tag, rob_en, r1_done); end
    tick();
  endtask

  task automatic test_back_to_back();
    bit found = 0;
    do_reset();
    issue_n(4);
    cdb(4'd0, 32'h40);
    issue_en = 1; issue_rd = 0; settle();
    checks++; if (rob_en !== 1'b1 || count !== 5'd4 || issue_tag !== 4'd4)
      begin errors++; $display("FAIL b2b_during: got en=%b count=%0d tag=%0d exp 1/4/4", rob_en, count, issue_tag); end
    tick(); idle(); settle();
    checks++; if (count !== 5'd4 || issue_tag !== 4'd5 || rob_en !== 1'b0)
      begin errors++; $display("FAIL b2b_after: got count=%0d tag=%0d en=%b exp 4/5/0", count, issue_tag, rob_en); end
    tick();
    for (int t = 1; t <= 4; t++) cdb(4'(t), 32'(t * 16));
    for (int k = 0; k < 8 && !found; k++) begin
      idle(); settle();
      if (rob_en === 1'b1 && rob_tag === 4'd4) begin
        found = 1;
        checks++; if (rob_dest !== 5'd0 || rob_data !== 32'd64) begin errors++; $display("FAIL b2b_x0_commit: got dest=%0d data=%h exp 0/40", rob_dest, rob_data); end
      end
      tick();
    end
    checks++; if (!found) begin errors++; $display("FAIL b2b_x0_timeout: got no commit of tag 4 exp commit"); end
  endtask

  task automatic test_rst_mid();
    do_reset();
    issue_n(3);
    cdb(4'd2, 32'h2);
    cdb(4'd1, 32'h1);
    cdb(4'd0, 32'h0);
    rst = 1; settle();
    checks++; if (rob_en !== 1'b1 || count !== 5'd3) begin errors++; $display("FAIL rst_pending: got en=%b count=%0d exp 1/3", rob_en, count); end
    tick(); rst = 0; settle();
    checks++; if (rob_en !== 1'b0 || count !== 5'd0 || issue_tag !== 4'd0)
      begin errors++; $display("FAIL rst_mid: got en=%b count=%0d tag=%0d exp 0/0/0", rob_en, count, issue_tag); end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      idle();
      rst      = ($urandom_range(0, 99) == 0);
      flush    = ($urandom_range(0, 39) == 0);
      issue_en = ($urandom_range(0, 9) < 6);
      issue_rd = 5'($urandom);
      cdb_en   = ($urandom_range(0, 9) < 6);
      cdb_data = $urandom;
      cdb_tag  = (mq.size() > 0 && $urandom_range(0, 3) != 0) ? mq[$urandom_range(0, mq.size() - 1)].tag : 4'($urandom);
      r1_tag   = (mq.size() > 0) ? mq[$urandom_range(0, mq.size() - 1)].tag : 4'($urandom);
      r2_tag   = 4'($urandom);
      settle();
      checks++; if (issue_ready !== exp_ready || issue_tag !== exp_itag || count !== exp_count)
        begin errors++; $display("FAIL rand_alloc @%0d: got ready=%b tag=%0d count=%0d exp %b/%0d/%0d", n, issue_ready, issue_tag, count, exp_ready, exp_itag, exp_count); end
      checks++; if (rob_en !== exp_en || rob_dest !== exp_dest || rob_tag !== exp_rtag || rob_data !== exp_data)
        begin errors++; $display("FAIL rand_commit @%0d: got %b/%0d/%0d/%h exp %b/%0d/%0d/%h", n, rob_en, rob_dest, rob_tag, rob_data, exp_en, exp_dest, exp_rtag, exp_data); end
      checks++; if (r1_done !== exp_r1_done || (exp_r1_known && r1_data !== exp_r1_data))
        begin errors++; $display("FAIL rand_r1 @%0d: got %b/%h exp %b/%h", n, r1_done, r1_data, exp_r1_done, exp_r1_data); end
      checks++; if (r2_done !== exp_r2_done || (exp_r2_known && r2_data !== exp_r2_data))
        begin errors++; $display("FAIL rand_r2 @%0d: got %b/%h exp %b/%h", n, r2_done, r2_data, exp_r2_done, exp_r2_data); end
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_in_order();
    test_full_wrap();
    test_bypass();
    test_flush();
    test_back_to_back();
    test_rst_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
